// File: rtl/shift_issue_buf.sv
// Two-entry in-order issue buffer (main + skid) between decode and the shifter.
// Handshake outputs decode from the state register alone, so no ready/valid path is combinational.
module shift_issue_buf #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_in1,
    input  logic [XLEN-1:0] in_in2,
    input  logic [1:0]      in_sel,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [1:0]      out_sel,
    output logic [RD_W-1:0] out_rd
);

    localparam int PW = 2*XLEN + 2 + RD_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] main_reg, main_next;
    logic [PW-1:0] skid_reg, skid_next;
    logic [PW-1:0] in_payload;
    logic          accept;
    logic          drain;

    assign in_ready   = (state_reg != FULL);
    assign out_valid  = (state_reg != EMPTY);
    assign accept     = in_valid & in_ready;
    assign drain      = out_valid & out_ready;
    assign in_payload = {in_in1, in_in2, in_sel, in_rd};
    assign {out_in1, out_in2, out_sel, out_rd} = main_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            // Payload is left untouched; with no valid entry it is don't-care.
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_next  = in_payload;
                        state_next = HALF;
                    end
                end
                HALF: begin
                    if (accept && drain) begin
                        main_next = in_payload;
                    end else if (accept) begin
                        skid_next  = in_payload;
                        state_next = FULL;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_next  = skid_reg;
                        state_next = HALF;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: doc/shift_issue_buf.md
SHIFT_ISSUE_BUF -- requirements
Module: shift_issue_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width.
REQ-002 SHALL have parameter RD_W, default 5, destination-register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  decode stage presents an operation.
REQ-006 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port in_in1  input  XLEN  shift source operand.
REQ-008 SHALL have port in_in2  input  XLEN  shift amount operand.
REQ-009 SHALL have port in_sel  input  2  shift operation select, passed through unchanged.
REQ-010 SHALL have port in_rd  input  RD_W  destination register index.
REQ-011 SHALL have port flush  input  1  discard all buffered and incoming operations.
REQ-012 SHALL have port out_valid  output  1  operation presented to the shifter stage.
REQ-013 SHALL have port out_ready  input  1  shifter/writeback stage consumes this cycle.
REQ-014 SHALL have port out_in1  output  XLEN  drives shifter in1.
REQ-015 SHALL have port out_in2  output  XLEN  drives shifter in2.
REQ-016 SHALL have port out_sel  output  2  drives shifter sel.
REQ-017 SHALL have port out_rd  output  RD_W  destination index travelling with the result.

Function
REQ-018 SHALL be a two-entry in-order buffer: main entry (drives out_*) and skid entry; states EMPTY (0 entries), HALF (1), FULL (2).
REQ-019 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready.
REQ-020 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both decoded from state registers only, with no combinational path from in_valid or out_ready.
REQ-021 EMPTY: on accept, main <= input and next state HALF; otherwise remain EMPTY.
REQ-022 HALF: on accept & drain, main <= input and remain HALF; on accept only, skid <= input and go FULL; on drain only, go EMPTY; otherwise hold.
REQ-023 FULL: on drain, main <= skid and go HALF; otherwise hold. No accept is possible.
REQ-024 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL present operations in acceptance order, with no loss or duplication.
REQ-026 SHALL give 1-cycle latency: an operation accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY or drained in cycle N.
REQ-027 SHALL copy payload bits unmodified, with no masking of in2 and no decoding of sel.
REQ-028 flush SHALL take priority over accept and drain: next state EMPTY, and any same-cycle accept is discarded (in_ready still reflects the current state).
REQ-029 out_* payload values SHALL be don't-care when out_valid=0, except immediately after reset (REQ-031).

Reset
REQ-030 rst=1 at a clock edge SHALL force state EMPTY, giving in_ready=1 and out_valid=0 the next cycle, regardless of in_valid, out_ready or flush.
REQ-031 Reset SHALL clear main and skid payload registers to 0, so out_in1 = out_in2 = 0, out_sel = 0 and out_rd = 0.
REQ-032 Reset asserted mid-operation (HALF or FULL) SHALL discard all entries; no buffered operation appears after reset.

Verification
REQ-033 Bench SHALL cover streaming: out_ready=1, accept in1=0x0000_00F0, in2=4, sel=1, rd=3, then in1=0x8000_0000, in2=31, sel=2, rd=7 on consecutive cycles -> each appears one cycle later in order, in_ready constantly 1.
REQ-034 Bench SHALL cover backpressure: out_ready=0, offer 3 ops (A, B, C) -> A and B accepted, in_ready=0 on the third cycle, C held; then out_ready=1 -> A, B, C drained in order with no gaps.
REQ-035 Bench SHALL cover simultaneous accept and drain in HALF: main=A, accept B with out_ready=1 -> next cycle out_* = B, state HALF.
REQ-036 Bench SHALL cover flush: FULL with A, B and in_valid=1 carrying C, flush=1 -> next cycle out_valid=0, in_ready=1, and A, B, C never appear.
REQ-037 Bench SHALL cover reset mid-operation: state FULL, rst=1 for one cycle -> out_valid=0, in_ready=1, out_in1 = out_in2 = 0, out_sel = 0, out_rd = 0.
REQ-038 Bench SHALL cover hold stability: FULL, out_ready=0 for 10 cycles with random in_* -> out_* unchanged every cycle.
